// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side port bundle of the async FIFO read-pointer controller.
// The master is the consumer/bench side; the slave is the controller itself.
interface fifo_rd_ptr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  localparam int PW = ADDR_WIDTH + 1;

  logic                  r_inc;
  logic [PW-1:0]         sync_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PW-1:0]         gray_rd_ptr;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic [PW-1:0]         r_level;
  logic                  r_underflow;

  modport master (
    output r_inc,
    output sync_wr_ptr,
    input  r_addr,
    input  gray_rd_ptr,
    input  r_empty,
    input  r_almost_empty,
    input  r_level,
    input  r_underflow
  );

  modport slave (
    input  r_inc,
    input  sync_wr_ptr,
    output r_addr,
    output gray_rd_ptr,
    output r_empty,
    output r_almost_empty,
    output r_level,
    output r_underflow
  );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer controller for a Gray-pointer asynchronous FIFO:
// binary/Gray read pointer, registered empty/almost-empty/level flags and underflow pulse.
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic              r_clk,
  input  logic              r_rst,
  fifo_rd_ptr_ctrl_if.slave rd_if
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

  logic [PW-1:0] rdBin_q;
  logic [PW-1:0] grayRd_q;
  logic          empty_q;
  logic          almostEmpty_q;
  logic [PW-1:0] level_q;
  logic          underflow_q;

  logic          pop;
  logic [PW-1:0] rdNext_d;
  logic [PW-1:0] grayRd_d;
  logic [PW-1:0] wrBin;
  logic          empty_d;
  logic          almostEmpty_d;
  logic [PW-1:0] level_d;
  logic          underflow_d;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    wrBin = '0;
    for (int i = 0; i < PW; i++) begin
      wrBin[i] = ^(rd_if.sync_wr_ptr >> i);
    end
  end

  // Flags are computed from the post-pop pointer so empty lands on the last pop's edge.
  always_comb begin
    pop           = rd_if.r_inc & ~empty_q;
    rdNext_d      = rdBin_q + {{(PW-1){1'b0}}, pop};
    grayRd_d      = rdNext_d ^ (rdNext_d >> 1);
    level_d       = wrBin - rdNext_d;
    empty_d       = (grayRd_d == rd_if.sync_wr_ptr);
    almostEmpty_d = (level_d <= AE_THRESH);
    underflow_d   = rd_if.r_inc & empty_q;
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      rdBin_q       <= '0;
      grayRd_q      <= '0;
      empty_q       <= 1'b1;
      almostEmpty_q <= 1'b1;
      level_q       <= '0;
      underflow_q   <= 1'b0;
    end else begin
      rdBin_q       <= rdNext_d;
      grayRd_q      <= grayRd_d;
      empty_q       <= empty_d;
      almostEmpty_q <= almostEmpty_d;
      level_q       <= level_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rd_if.r_addr         = rdBin_q[ADDR_WIDTH-1:0];
  assign rd_if.gray_rd_ptr    = grayRd_q;
  assign rd_if.r_empty        = empty_q;
  assign rd_if.r_almost_empty = almostEmpty_q;
  assign rd_if.r_level        = level_q;
  assign rd_if.r_underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed plus randomized bench for fifo_rd_ptr_ctrl, checked against an
// occupancy-count model of the read side (ADDR_WIDTH=3, AE_LEVEL=1).
module tb_fifo_rd_ptr_ctrl;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int AE    = 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;

  logic r_clk = 1'b0;
  logic r_rst;

  int errors = 0;
  int checks = 0;

  // Model state: pointer counts as plain integers plus the expected registered outputs.
  int mRd;
  int mWr;
  int eLevel;
  bit eEmpty;
  bit eAe;
  bit eUnder;

  fifo_rd_ptr_ctrl_if #(.ADDR_WIDTH(AW)) rdIf ();

  fifo_rd_ptr_ctrl #(
    .ADDR_WIDTH(AW),
    .AE_LEVEL  (AE)
  ) dut (
    .r_clk(r_clk),
    .r_rst(r_rst),
    .rd_if(rdIf.slave)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [PW-1:0] toGray(input int b);
    logic [PW-1:0] v;
    v = b[PW-1:0];
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".r_addr"},         32'(rdIf.r_addr),         32'(mRd % DEPTH));
    checkOutput({ctx, ".gray_rd_ptr"},    32'(rdIf.gray_rd_ptr),    32'(toGray(mRd)));
    checkOutput({ctx, ".r_empty"},        32'(rdIf.r_empty),        32'(eEmpty));
    checkOutput({ctx, ".r_almost_empty"}, 32'(rdIf.r_almost_empty), 32'(eAe));
    checkOutput({ctx, ".r_level"},        32'(rdIf.r_level),        32'(eLevel));
    checkOutput({ctx, ".r_underflow"},    32'(rdIf.r_underflow),    32'(eUnder));
  endtask

  task automatic modelReset();
    mRd    = 0;
    eLevel = 0;
    eEmpty = 1'b1;
    eAe    = 1'b1;
    eUnder = 1'b0;
  endtask

  // Inputs are already driven; advance one edge, update the model, then check.
  task automatic applyStimulus(input string ctx);
    bit inc;
    bit popNow;
    @(posedge r_clk);
    inc    = rdIf.r_inc;
    popNow = inc && !eEmpty;
    eUnder = inc && eEmpty;
    mRd    = (mRd + (popNow ? 1 : 0)) % PMOD;
    eLevel = (mWr - mRd + PMOD) % PMOD;
    eEmpty = (eLevel == 0);
    eAe    = (eLevel <= AE);
    #1;
    checkAll(ctx);
  endtask

  task automatic driveWr(input int w);
    mWr = w % PMOD;
    rdIf.sync_wr_ptr = toGray(mWr);
  endtask

  initial begin
    r_rst       = 1'b1;
    rdIf.r_inc  = 1'b0;
    mWr         = 0;
    rdIf.sync_wr_ptr = '0;
    modelReset();
    #2;
    checkAll("reset");
    @(posedge r_clk);
    #1;
    checkAll("resetHeld");
    r_rst = 1'b0;

    driveWr(3);
    applyStimulus("fill3");

    rdIf.r_inc = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus("drain3");
    checkOutput("drain3.grayEnd", 32'(rdIf.gray_rd_ptr), 32'h2);

    applyStimulus("underflow");
    rdIf.r_inc = 1'b0;
    applyStimulus("underflowEnd");

    r_rst = 1'b1;
    driveWr(0);
    modelReset();
    #1;
    checkAll("reset2");
    @(posedge r_clk);
    #1;
    r_rst = 1'b0;
    driveWr(8);
    applyStimulus("full");
    checkOutput("full.level8", 32'(rdIf.r_level), 32'd8);

    rdIf.r_inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      driveWr(mWr + 1);
      applyStimulus("wrapStream");
    end

    for (int k = 0; k < 300; k++) begin
      rdIf.r_inc = ($urandom_range(0, 99) < 55);
      if (((mWr - mRd + PMOD) % PMOD) < DEPTH && ($urandom_range(0, 1) == 1))
        driveWr(mWr + 1);
      applyStimulus("random");
    end

    rdIf.r_inc = 1'b1;
    for (int k = 0; k < 2 * DEPTH && !eEmpty; k++) applyStimulus("preDrain");
    rdIf.r_inc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      driveWr(mWr + 1);
      applyStimulus("toLevel5");
    end
    checkOutput("midReset.level5", 32'(rdIf.r_level), 32'd5);
    rdIf.r_inc = 1'b1;
    #3;
    r_rst = 1'b1;
    modelReset();
    #1;
    checkAll("asyncReset");
    driveWr(0);
    @(posedge r_clk);
    #1;
    checkAll("asyncResetHeld");
    r_rst = 1'b0;
    applyStimulus("releaseNoPop");
    rdIf.r_inc = 1'b0;
    driveWr(2);
    applyStimulus("postReset");
    rdIf.r_inc = 1'b1;
    applyStimulus("postResetPop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
